// File: rtl/cc3000_apb_spi.sv
// APB3 slave with TX/RX byte FIFOs feeding a mode-1 SPI master for the CC3000,
// plus a synchronised IRQ_N input and a level interrupt to the MSS.
module cc3000_apb_spi #(
    parameter int          FIFO_DEPTH  = 8,
    parameter int          ADDR_WIDTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd4
) (
    input  logic                  SYSCLK,
    input  logic                  SYSRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]           PWDATA,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  SPI_SCLK,
    output logic                  SPI_MOSI,
    input  logic                  SPI_MISO,
    output logic                  SPI_CS_N,
    input  logic                  SPI_IRQ_N,
    output logic                  FABINT
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT_H, S_SHIFT_L, S_DONE} state_t;

    state_t       state_q, state_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [2:0]   bit_q, bit_d;
    logic [7:0]   sh_q, sh_d;
    logic [4:0]   ctrl_q;
    logic [15:0]  clkdiv_q;
    logic         ovf_q, irq1_q, irq2_q, fabint_q;
    logic         sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
    logic [PW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
    logic [7:0]   tx_mem [FIFO_DEPTH];
    logic [7:0]   rx_mem [FIFO_DEPTH];

    logic       strobe, wr_data, rd_data, wr_ctrl, wr_div;
    logic       tx_full, tx_empty, rx_full, rx_empty;
    logic       tx_push, tx_pop, rx_push, rx_pop, ovf_set, busy, irq_sync;
    logic [7:0] tx_head, rx_head;
    logic       unused_bits;

    assign strobe  = PSEL & PENABLE;
    assign wr_data = strobe &  PWRITE & (PADDR[3:2] == 2'd0);
    assign rd_data = strobe & ~PWRITE & (PADDR[3:2] == 2'd0);
    assign wr_ctrl = strobe &  PWRITE & (PADDR[3:2] == 2'd2);
    assign wr_div  = strobe &  PWRITE & (PADDR[3:2] == 2'd3);
    assign unused_bits = ^{PADDR, PWDATA[31:16]};

    // Full: MSBs differ, index bits equal
    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
    assign tx_head  = tx_mem[tx_rd_q[AW-1:0]];
    assign rx_head  = rx_mem[rx_rd_q[AW-1:0]];

    assign tx_push  = wr_data & ~tx_full;
    assign rx_pop   = rd_data & ~rx_empty;
    assign busy     = (state_q != S_IDLE);
    assign irq_sync = ~irq2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        tx_pop  = 1'b0;
        rx_push = 1'b0;
        ovf_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ctrl_q[0] && !tx_empty) begin
                    tx_pop  = 1'b1;
                    sh_d    = tx_head;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_SHIFT_H;
                cnt_d   = clkdiv_q;
                bit_d   = 3'd0;
            end
            S_SHIFT_H: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_SHIFT_L;
                    cnt_d   = clkdiv_q;
                    sh_d    = {sh_q[6:0], SPI_MISO};
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_SHIFT_L: begin
                if (cnt_q == 16'd0) begin
                    if (bit_q == 3'd7) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHIFT_H;
                        cnt_d   = clkdiv_q;
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DONE: begin
                if (rx_full) ovf_set = 1'b1;
                else         rx_push = 1'b1;
                if (ctrl_q[0] && !tx_empty) begin
                    tx_pop  = 1'b1;
                    sh_d    = tx_head;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pin registers follow the next state so SCLK/MOSI/CS line up with the FSM
    always_comb begin
        sclk_d = (state_d == S_SHIFT_H);
        mosi_d = (state_d == S_SHIFT_H) ? sh_d[7] : mosi_q;
        cs_n_d = ctrl_q[1] ? ~ctrl_q[2] : (state_d == S_IDLE);
    end

    always_ff @(posedge SYSCLK or posedge SYSRESET) begin
        if (SYSRESET) begin
            state_q  <= S_IDLE;
            cnt_q    <= 16'd0;
            bit_q    <= 3'd0;
            ctrl_q   <= 5'd0;
            clkdiv_q <= DEFAULT_DIV;
            ovf_q    <= 1'b0;
            irq1_q   <= 1'b1;
            irq2_q   <= 1'b1;
            fabint_q <= 1'b0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            cs_n_q   <= cs_n_d;
            irq1_q   <= SPI_IRQ_N;
            irq2_q   <= irq1_q;
            fabint_q <= (ctrl_q[3] & ~rx_empty) | (ctrl_q[4] & irq_sync);
            if (wr_ctrl) ctrl_q <= PWDATA[4:0];
            if (wr_div)  clkdiv_q <= PWDATA[15:0];
            if (ovf_set)                     ovf_q <= 1'b1;
            else if (wr_ctrl && PWDATA[5])   ovf_q <= 1'b0;
            if (tx_push) tx_wr_q <= tx_wr_q + PW'(1);
            if (tx_pop)  tx_rd_q <= tx_rd_q + PW'(1);
            if (rx_push) rx_wr_q <= rx_wr_q + PW'(1);
            if (rx_pop)  rx_rd_q <= rx_rd_q + PW'(1);
        end
    end

    always_ff @(posedge SYSCLK) begin
        sh_q <= sh_d;
        if (tx_push) tx_mem[tx_wr_q[AW-1:0]] <= PWDATA[7:0];
        if (rx_push) rx_mem[rx_wr_q[AW-1:0]] <= sh_q;
    end

    always_comb begin
        PRDATA  = 32'd0;
        PSLVERR = 1'b0;
        if (strobe) begin
            case (PADDR[3:2])
                2'd0: begin
                    if (PWRITE)        PSLVERR = tx_full;
                    else if (rx_empty) PSLVERR = 1'b1;
                    else               PRDATA  = {24'd0, rx_head};
                end
                2'd1: begin
                    if (PWRITE) PSLVERR = 1'b1;
                    else PRDATA = {25'd0, irq_sync, ovf_q, busy, rx_empty, rx_full, tx_empty, tx_full};
                end
                2'd2: if (!PWRITE) PRDATA = {27'd0, ctrl_q};
                default: if (!PWRITE) PRDATA = {16'd0, clkdiv_q};
            endcase
        end
    end

    assign PREADY   = 1'b1;
    assign SPI_SCLK = sclk_q;
    assign SPI_MOSI = mosi_q;
    assign SPI_CS_N = cs_n_q;
    assign FABINT   = fabint_q;
endmodule
